// File: rtl/debug_unit.sv
// Host debug controller for pipeline: command decode, program load, run/step, state dump over UART.
// Optional data-memory dump section enabled by defining DEBUG_UNIT_MEM_DUMP_EN.
module debug_unit #(
  parameter int NB_IF_ID        = 64,
  parameter int NB_ID_EX        = 139,
  parameter int NB_EX_MEM       = 76,
  parameter int NB_MEM_WB       = 71,
  parameter int DMEM_DUMP_WORDS = 8,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_halt,
  output logic                 o_write_instruction_mem,
  output logic [31:0]          o_instruction_mem_addr,
  output logic [31:0]          o_instruction_mem_data,
  output logic [4:0]           o_r_addr_registers,
  output logic [4:0]           o_r_addr_data_mem,
  input  logic [31:0]          i_r_data_registers,
  input  logic [31:0]          i_r_data_data_mem,
  input  logic [NB_IF_ID-1:0]  i_IF_ID,
  input  logic [NB_ID_EX-1:0]  i_ID_EX,
  input  logic [NB_EX_MEM-1:0] i_EX_MEM,
  input  logic [NB_MEM_WB-1:0] i_MEM_WB,
  input  logic                 i_end
);

  localparam int IF_B        = (NB_IF_ID + 7) / 8;
  localparam int ID_B        = (NB_ID_EX + 7) / 8;
  localparam int EX_B        = (NB_EX_MEM + 7) / 8;
  localparam int WB_B        = (NB_MEM_WB + 7) / 8;
  localparam int LATCH_BYTES = IF_B + ID_B + EX_B + WB_B;
  localparam int LATCH_BITS  = 8 * LATCH_BYTES;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] HDR_END  = 8'h45;
  localparam logic [7:0] HDR_STEP = 8'h53;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ACK, S_RUN, S_STEP,
    S_HDR, S_LATCH, S_RD_WAIT, S_RD_CAP, S_RD_SEND
  } state_t;

  state_t                  state;
  logic [1:0]              byte_cnt;
  logic [23:0]             word_acc;
  logic                    ended;
  logic                    end_seen;
  logic [31:0]             drain_cnt;
  logic                    tx_busy;
  logic [LATCH_BITS-1:0]   snap;
  logic [15:0]             latch_cnt;
  logic                    rd_mem;
  logic [4:0]              rd_idx;
  logic [31:0]             word_buf;

  logic [8*IF_B-1:0]       if_pad;
  logic [8*ID_B-1:0]       id_pad;
  logic [8*EX_B-1:0]       ex_pad;
  logic [8*WB_B-1:0]       wb_pad;
  logic [LATCH_BITS-1:0]   latch_cat;

  always_comb begin
    if_pad = '0;
    id_pad = '0;
    ex_pad = '0;
    wb_pad = '0;
    if_pad[NB_IF_ID-1:0]  = i_IF_ID;
    id_pad[NB_ID_EX-1:0]  = i_ID_EX;
    ex_pad[NB_EX_MEM-1:0] = i_EX_MEM;
    wb_pad[NB_MEM_WB-1:0] = i_MEM_WB;
  end

  assign latch_cat = {if_pad, id_pad, ex_pad, wb_pad};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                   <= S_IDLE;
      o_halt                  <= 1'b1;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= '0;
      o_instruction_mem_data  <= '0;
      o_r_addr_registers      <= '0;
      o_r_addr_data_mem       <= '0;
      o_tx_start              <= 1'b0;
      o_tx_data               <= '0;
      byte_cnt                <= '0;
      word_acc                <= '0;
      ended                   <= 1'b0;
      end_seen                <= 1'b0;
      drain_cnt               <= '0;
      tx_busy                 <= 1'b0;
      snap                    <= '0;
      latch_cnt               <= '0;
      rd_mem                  <= 1'b0;
      rd_idx                  <= '0;
      word_buf                <= '0;
    end else begin
      o_tx_start              <= 1'b0;
      o_write_instruction_mem <= 1'b0;
      if (i_tx_done) tx_busy <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state                  <= S_LOAD;
                o_instruction_mem_addr <= '0;
                byte_cnt               <= '0;
              end
              CMD_RUN: begin
                state     <= S_RUN;
                o_halt    <= 1'b0;
                end_seen  <= 1'b0;
                drain_cnt <= '0;
              end
              CMD_STEP: begin
                if (ended) begin
                  state <= S_HDR;
                  snap  <= latch_cat;
                end else begin
                  state  <= S_STEP;
                  o_halt <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end

        // A byte arriving during the write cycle starts the next word, unless this write is HALT.
        S_LOAD: begin
          if (o_write_instruction_mem) begin
            o_instruction_mem_addr <= o_instruction_mem_addr + 32'd4;
            if (o_instruction_mem_data == '1) begin
              ended <= 1'b0;
              state <= S_ACK;
            end
          end
          if (i_rx_done && !(o_write_instruction_mem && o_instruction_mem_data == '1)) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_acc <= {word_acc[15:0], i_rx_data};
            if (byte_cnt == 2'd3) begin
              o_instruction_mem_data  <= {word_acc, i_rx_data};
              o_write_instruction_mem <= 1'b1;
            end
          end
        end

        S_ACK: begin
          if (!tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= CMD_LOAD;
            tx_busy    <= 1'b1;
            state      <= S_IDLE;
          end
        end

        // The cycle in which i_end is first seen counts as the start of the drain.
        S_RUN: begin
          if (end_seen || i_end) begin
            end_seen <= 1'b1;
            if (drain_cnt == 32'(DRAIN_CYCLES)) begin
              o_halt <= 1'b1;
              ended  <= 1'b1;
              state  <= S_HDR;
              snap   <= latch_cat;
            end else begin
              drain_cnt <= drain_cnt + 32'd1;
            end
          end
        end

        S_STEP: begin
          o_halt <= 1'b1;
          if (i_end) ended <= 1'b1;
          state <= S_HDR;
          snap  <= latch_cat;
        end

        S_HDR: begin
          if (!tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= ended ? HDR_END : HDR_STEP;
            tx_busy    <= 1'b1;
            latch_cnt  <= '0;
            state      <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (!tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= snap[LATCH_BITS-1 -: 8];
            tx_busy    <= 1'b1;
            snap       <= snap << 8;
            latch_cnt  <= latch_cnt + 16'd1;
            if (latch_cnt == 16'(LATCH_BYTES - 1)) begin
              rd_mem             <= 1'b0;
              rd_idx             <= '0;
              o_r_addr_registers <= '0;
              state              <= S_RD_WAIT;
            end
          end
        end

        S_RD_WAIT: state <= S_RD_CAP;

        S_RD_CAP: begin
          word_buf <= rd_mem ? i_r_data_data_mem : i_r_data_registers;
          byte_cnt <= '0;
          state    <= S_RD_SEND;
        end

        S_RD_SEND: begin
          if (!tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= word_buf[31:24];
            tx_busy    <= 1'b1;
            word_buf   <= word_buf << 8;
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (!rd_mem) begin
                if (rd_idx == 5'd31) begin
`ifdef DEBUG_UNIT_MEM_DUMP_EN
                  rd_mem            <= 1'b1;
                  rd_idx            <= '0;
                  o_r_addr_data_mem <= '0;
                  state             <= S_RD_WAIT;
`else
                  state             <= S_IDLE;
`endif
                end else begin
                  rd_idx             <= rd_idx + 5'd1;
                  o_r_addr_registers <= rd_idx + 5'd1;
                  state              <= S_RD_WAIT;
                end
              end else begin
                if (rd_idx == 5'(DMEM_DUMP_WORDS - 1)) begin
                  state <= S_IDLE;
                end else begin
                  rd_idx            <= rd_idx + 5'd1;
                  o_r_addr_data_mem <= {rd_idx[2:0] + 3'd1, 2'b00};
                  state             <= S_RD_WAIT;
                end
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
